rom_port_arbiter: RTL and testbench

- Shares the single game ROM/RAM memory port between three requesters:
  - the HPS ROM download stream (writes),
  - the game CPU fetch (reads),
  - the video/graphics fetch (reads).
- Sits between hps_io's ioctl bus, the game core and the memory controller.
- Generates the core reset hold: asserted during download and for a fixed number of cycles after it ends.

---
 rtl/rom_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Shares the game ROM/RAM port between the HPS download writer, CPU reads and
// graphics reads, and holds the core in reset around downloads. Optional ARB_TIMEOUT_EN.
module rom_port_arbiter #(
  parameter int AW          = 17,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dn_active,
  input  logic          dn_wr,
  input  logic [AW-1:0] dn_addr,
  input  logic [7:0]    dn_data,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [7:0]    cpu_data,
  input  logic          gfx_req,
  input  logic [AW-1:0] gfx_addr,
  output logic          gfx_ack,
  output logic [7:0]    gfx_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic          mem_ack,
  input  logic [7:0]    mem_dout,
  output logic          game_reset,
  output logic          dn_overrun,
  output logic          mem_timeout
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_reg, state_next;
  logic            buf_full_reg;
  logic [AW-1:0]   buf_addr_reg;
  logic [7:0]      buf_data_reg;
  logic            prio_gfx_reg;
  logic            cur_gfx_reg;
  logic            mem_req_reg, mem_we_reg;
  logic [AW-1:0]   mem_addr_reg;
  logic [7:0]      mem_din_reg;
  logic            cpu_ack_reg, gfx_ack_reg;
  logic [7:0]      cpu_data_reg, gfx_data_reg;
  logic            overrun_reg;
  logic            game_reset_reg;
  logic [7:0]      hold_cnt_reg;

  logic            cpu_elig, gfx_elig;
  logic            grant_wr, grant_cpu, grant_gfx;
  logic            complete, buf_free;
  logic [7:0]      rd_data;
  logic            timeout_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_reg;
  logic          to_flag_reg;

  assign timeout_hit = (state_reg == S_WAIT) && !mem_ack && (to_cnt_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      to_cnt_reg  <= '0;
      to_flag_reg <= 1'b0;
    end else begin
      to_cnt_reg <= (state_reg == S_WAIT) ? to_cnt_reg + 1'b1 : '0;
      if (timeout_hit)
        to_flag_reg <= 1'b1;
    end
  end

  assign mem_timeout = to_flag_reg;
`else
  assign timeout_hit = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    grant_wr   = 1'b0;
    grant_cpu  = 1'b0;
    grant_gfx  = 1'b0;
    complete   = 1'b0;
    rd_data    = mem_ack ? mem_dout : 8'hFF;
    // A requester whose ack is high this cycle sits out, so it can drop req cleanly.
    cpu_elig   = cpu_req && !cpu_ack_reg && !dn_active && !buf_full_reg;
    gfx_elig   = gfx_req && !gfx_ack_reg && !dn_active && !buf_full_reg;
    case (state_reg)
      S_IDLE: begin
        if (buf_full_reg) begin
          grant_wr = 1'b1;
        end else begin
          grant_cpu = cpu_elig && (!gfx_elig || !prio_gfx_reg);
          grant_gfx = gfx_elig && (!cpu_elig || prio_gfx_reg);
        end
        if (grant_wr || grant_cpu || grant_gfx)
          state_next = S_WAIT;
      end
      S_WAIT: begin
        complete = mem_ack || timeout_hit;
        if (complete)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign buf_free = complete && mem_we_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_req_reg  <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      cur_gfx_reg  <= 1'b0;
      prio_gfx_reg <= 1'b0;
      cpu_ack_reg  <= 1'b0;
      gfx_ack_reg  <= 1'b0;
      cpu_data_reg <= '0;
      gfx_data_reg <= '0;
    end else begin
      cpu_ack_reg <= 1'b0;
      gfx_ack_reg <= 1'b0;
      if (grant_wr || grant_cpu || grant_gfx) begin
        mem_req_reg  <= 1'b1;
        mem_we_reg   <= grant_wr;
        cur_gfx_reg  <= grant_gfx;
        mem_addr_reg <= grant_wr ? buf_addr_reg : (grant_cpu ? cpu_addr : gfx_addr);
        if (grant_wr)
          mem_din_reg <= buf_data_reg;
      end
      if (grant_cpu)
        prio_gfx_reg <= 1'b1;
      else if (grant_gfx)
        prio_gfx_reg <= 1'b0;
      if (complete) begin
        mem_req_reg <= 1'b0;
        if (!mem_we_reg) begin
          if (cur_gfx_reg) begin
            gfx_ack_reg  <= 1'b1;
            gfx_data_reg <= rd_data;
          end else begin
            cpu_ack_reg  <= 1'b1;
            cpu_data_reg <= rd_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      buf_full_reg <= 1'b0;
      buf_addr_reg <= '0;
      buf_data_reg <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      if (dn_wr && (!buf_full_reg || buf_free)) begin
        buf_full_reg <= 1'b1;
        buf_addr_reg <= dn_addr;
        buf_data_reg <= dn_data;
      end else if (buf_free) begin
        buf_full_reg <= 1'b0;
      end
      if (dn_wr && buf_full_reg && !buf_free)
        overrun_reg <= 1'b1;
    end
  end

  // The buffer stays full until its write completes, so an empty buffer also
  // means no write is in flight.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      game_reset_reg <= 1'b1;
      hold_cnt_reg   <= '0;
    end else if (dn_active) begin
      game_reset_reg <= 1'b1;
      hold_cnt_reg   <= '0;
    end else if (buf_full_reg) begin
      hold_cnt_reg <= '0;
    end else if (game_reset_reg) begin
      if (hold_cnt_reg == 8'(HOLD_CYCLES - 1))
        game_reset_reg <= 1'b0;
      else
        hold_cnt_reg <= hold_cnt_reg + 8'd1;
    end
  end

  assign cpu_ack    = cpu_ack_reg;
  assign cpu_data   = cpu_data_reg;
  assign gfx_ack    = gfx_ack_reg;
  assign gfx_data   = gfx_data_reg;
  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_din    = mem_din_reg;
  assign game_reset = game_reset_reg;
  assign dn_overrun = overrun_reg;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter; the timeout case follows ARB_TIMEOUT_EN.
module tb_rom_port_arbiter;

  localparam int AW = 17;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          dn_active, dn_wr;
  logic [AW-1:0] dn_addr;
  logic [7:0]    dn_data;
  logic          cpu_req, gfx_req;
  logic [AW-1:0] cpu_addr, gfx_addr;
  logic          cpu_ack, gfx_ack;
  logic [7:0]    cpu_data, gfx_data;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din, mem_dout;
  logic          game_reset, dn_overrun, mem_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  rom_port_arbiter #(.AW(AW), .HOLD_CYCLES(16), .TIMEOUT(64)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dn_active(dn_active), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_ack(gfx_ack), .gfx_data(gfx_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_dout(mem_dout),
    .game_reset(game_reset), .dn_overrun(dn_overrun), .mem_timeout(mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    if (!mem_req)
      check(tag, mem_req, 1);
  endtask

  task automatic count_req(input int cycles, output int hi);
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      if (mem_req) hi++;
      @(negedge clk_sys);
    end
  endtask

  task automatic count_reset_hold(input string tag);
    int hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (game_reset) hi++;
      @(negedge clk_sys);
    end
    check(tag, hi, 16);
  endtask

  // One read: wait for mem_req, ack after 'delay' cycles, check the 1-cycle ack pulse.
  task automatic serve(input string tag, input logic [AW-1:0] exp_addr, input logic [7:0] dout,
                       input bit exp_gfx, input int delay, input bit drop, input bit gap_chk);
    wait_req({tag, "_req"});
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, exp_addr);
    repeat (delay) @(negedge clk_sys);
    mem_ack  = 1'b1;
    mem_dout = dout;
    @(negedge clk_sys);
    mem_ack  = 1'b0;
    mem_dout = 8'h00;
    check({tag, "_cpu_ack"}, cpu_ack, !exp_gfx);
    check({tag, "_gfx_ack"}, gfx_ack, exp_gfx);
    check({tag, "_data"}, exp_gfx ? gfx_data : cpu_data, dout);
    if (drop) begin
      cpu_req = 1'b0;
      gfx_req = 1'b0;
    end
    @(negedge clk_sys);
    check({tag, "_ack_pulse"}, {30'd0, cpu_ack, gfx_ack}, 0);
    if (gap_chk)
      check({tag, "_gap"}, mem_req, 0);
  endtask

  task automatic dn_write(input logic [AW-1:0] a, input logic [7:0] d);
    dn_wr   = 1'b1;
    dn_addr = a;
    dn_data = d;
    @(negedge clk_sys);
    dn_wr   = 1'b0;
  endtask

  initial begin
    int hi;
    reset = 1'b1; dn_active = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    cpu_req = 1'b0; gfx_req = 1'b0; cpu_addr = '0; gfx_addr = '0;
    mem_ack = 1'b0; mem_dout = '0;

    // Reset state and post-reset hold
    repeat (2) @(negedge clk_sys);
    check("rst_mem_req", mem_req, 0);
    check("rst_game_reset", game_reset, 1);
    check("rst_acks", {30'd0, cpu_ack, gfx_ack}, 0);
    check("rst_overrun", dn_overrun, 0);
    check("rst_timeout", mem_timeout, 0);
    reset = 1'b0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (game_reset) hi++;
      if (mem_req) hi += 1000;
      @(negedge clk_sys);
    end
    check("rst_hold_len", hi, 16);

    // Round robin, both held: CPU, GFX, CPU
    cpu_addr = 17'h00100; gfx_addr = 17'h00200;
    cpu_req = 1'b1; gfx_req = 1'b1;
    serve("rr1_cpu", 17'h00100, 8'h11, 1'b0, 1, 1'b0, 1'b0);
    serve("rr2_gfx", 17'h00200, 8'h22, 1'b1, 1, 1'b0, 1'b0);
    serve("rr3_cpu", 17'h00100, 8'h11, 1'b0, 1, 1'b1, 1'b1);

    // Download write, mem_ack 3 cycles after mem_req
    dn_active = 1'b1;
    dn_write(17'h00010, 8'hA5);
    wait_req("wr1_req");
    check("wr1_we", mem_we, 1);
    check("wr1_addr", mem_addr, 17'h00010);
    check("wr1_din", mem_din, 8'hA5);
    repeat (2) @(negedge clk_sys);
    mem_ack = 1'b1;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    check("wr1_req_drop", mem_req, 0);
    check("wr1_overrun", dn_overrun, 0);
    check("dl_game_reset", game_reset, 1);

    // Buffer freed: next byte accepted; a byte during its WAIT is dropped
    dn_write(17'h00011, 8'h5A);
    wait_req("wr2_req");
    check("wr2_addr", mem_addr, 17'h00011);
    check("wr2_din", mem_din, 8'h5A);
    dn_write(17'h00012, 8'hC3);
    check("wr2_overrun", dn_overrun, 1);
    check("wr2_addr_hold", mem_addr, 17'h00011);
    mem_ack = 1'b1;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    count_req(6, hi);
    check("dropped_byte_no_req", hi, 0);

    // A byte arriving with the write's mem_ack is accepted
    dn_write(17'h00013, 8'h44);
    wait_req("wr3_req");
    mem_ack = 1'b1;
    dn_wr = 1'b1; dn_addr = 17'h00014; dn_data = 8'h55;
    @(negedge clk_sys);
    mem_ack = 1'b0; dn_wr = 1'b0;
    wait_req("wr4_req");
    check("wr4_addr", mem_addr, 17'h00014);
    check("wr4_din", mem_din, 8'h55);
    mem_ack = 1'b1;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    check("overrun_sticky", dn_overrun, 1);

    // Hold after download ends
    dn_active = 1'b0;
    count_reset_hold("dl_hold_len");

    // dn_active rises mid-read
    cpu_addr = 17'h00055;
    cpu_req = 1'b1;
    wait_req("mid_req");
    check("mid_addr", mem_addr, 17'h00055);
    dn_active = 1'b1;
    check("mid_game_reset0", game_reset, 0);
    @(negedge clk_sys);
    check("mid_game_reset1", game_reset, 1);
    mem_ack = 1'b1; mem_dout = 8'h77;
    @(negedge clk_sys);
    mem_ack = 1'b0; mem_dout = 8'h00;
    check("mid_cpu_ack", cpu_ack, 1);
    check("mid_cpu_data", cpu_data, 8'h77);
    count_req(10, hi);
    check("mid_no_grant", hi, 0);
    dn_active = 1'b0;
    serve("solo1", 17'h00055, 8'h66, 1'b0, 0, 1'b0, 1'b1);
    serve("solo2", 17'h00055, 8'h99, 1'b0, 2, 1'b1, 1'b1);

`ifdef ARB_TIMEOUT_EN
    cpu_addr = 17'h1FFFF;
    cpu_req = 1'b1;
    wait_req("to_req");
    hi = 0;
    while (mem_req && hi < 200) begin
      hi++;
      @(negedge clk_sys);
    end
    cpu_req = 1'b0;
    check("to_len", hi, 64);
    check("to_cpu_ack", cpu_ack, 1);
    check("to_cpu_data", cpu_data, 8'hFF);
    check("to_flag", mem_timeout, 1);
`else
    cpu_addr = 17'h1FFFF;
    cpu_req = 1'b1;
    wait_req("nto_req");
    count_req(100, hi);
    check("nto_hold", hi, 100);
    check("nto_flag", mem_timeout, 0);
    mem_ack = 1'b1; mem_dout = 8'h3C;
    @(negedge clk_sys);
    mem_ack = 1'b0; mem_dout = 8'h00;
    cpu_req = 1'b0;
    check("nto_cpu_ack", cpu_ack, 1);
    check("nto_cpu_data", cpu_data, 8'h3C);
`endif
    @(negedge clk_sys);

    // Asynchronous reset abandons an in-flight read
    cpu_addr = 17'h00300;
    cpu_req = 1'b1;
    wait_req("ar_req");
    cpu_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("ar_mem_req", mem_req, 0);
    check("ar_game_reset", game_reset, 1);
    check("ar_overrun", dn_overrun, 0);
    check("ar_timeout", mem_timeout, 0);
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
